mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch, load/store) round-robin memory arbiter; optional MEM_ARB_ALIGN_CHK_EN alignment check
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_mode,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    output logic              mem_is_read,
    output logic              mem_is_write,
    output logic [2:0]        mem_mode,
    input  logic [DATA_W-1:0] mem_read,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt_ls_q, gnt_ls_d;     // port owning the access in flight
    logic              last_ls_q, last_ls_d;   // port granted most recently
    logic              we_q, we_d;
    logic              bad_q, bad_d;           // access suppressed as misaligned
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_write_q, mem_write_d;
    logic [2:0]        mem_mode_q, mem_mode_d;
    logic              mem_is_read_q, mem_is_read_d;
    logic              mem_is_write_q, mem_is_write_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic              ls_err_q, ls_err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_bad;
    logic              if_elig, ls_elig, pick_ls;

    // Classify the pending load/store request as misaligned or not
`ifdef MEM_ARB_ALIGN_CHK_EN
    always_comb begin
        case (ls_mode)
            3'b000, 3'b100: ls_bad = 1'b0;
            3'b001, 3'b101: ls_bad = ls_addr[0];
            3'b010:         ls_bad = |ls_addr[1:0];
            default:        ls_bad = 1'b1;
        endcase
    end
`else
    always_comb begin
        ls_bad = 1'b0;
    end
`endif

    // Next-state and registered-output logic: grant in IDLE, strobe in ISSUE, respond in RESP
    always_comb begin
        state_d        = state_q;
        gnt_ls_d       = gnt_ls_q;
        last_ls_d      = last_ls_q;
        we_d           = we_q;
        bad_d          = bad_q;
        mem_addr_d     = mem_addr_q;
        mem_write_d    = mem_write_q;
        mem_mode_d     = mem_mode_q;
        mem_is_read_d  = 1'b0;
        mem_is_write_d = 1'b0;
        if_ack_d       = 1'b0;
        ls_ack_d       = 1'b0;
        ls_err_d       = 1'b0;
        if_rdata_d     = if_rdata_q;
        ls_rdata_d     = ls_rdata_q;
        // A port still showing its ack this cycle is finishing, not asking again
        if_elig        = if_req && !if_ack_q;
        ls_elig        = ls_req && !ls_ack_q;
        pick_ls        = ls_elig && (!if_elig || !last_ls_q);

        case (state_q)
            IDLE: begin
                if (if_elig || ls_elig) begin
                    state_d   = ISSUE;
                    gnt_ls_d  = pick_ls;
                    last_ls_d = pick_ls;
                    if (pick_ls) begin
                        mem_addr_d     = ls_addr;
                        mem_write_d    = ls_wdata;
                        mem_mode_d     = ls_mode;
                        we_d           = ls_we;
                        bad_d          = ls_bad;
                        mem_is_write_d = ls_we && !ls_bad;
                        mem_is_read_d  = !ls_we && !ls_bad;
                    end else begin
                        mem_addr_d     = if_addr;
                        mem_mode_d     = 3'b010;
                        we_d           = 1'b0;
                        bad_d          = 1'b0;
                        mem_is_read_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (gnt_ls_q) begin
                    ls_ack_d = 1'b1;
                    ls_err_d = bad_q;
                    if (!we_q && !bad_q) begin
                        ls_rdata_d = mem_read;
                    end
                end else begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_read;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_ls_q       <= 1'b0;
            last_ls_q      <= 1'b1;
            we_q           <= 1'b0;
            bad_q          <= 1'b0;
            mem_addr_q     <= '0;
            mem_write_q    <= '0;
            mem_mode_q     <= 3'b000;
            mem_is_read_q  <= 1'b0;
            mem_is_write_q <= 1'b0;
            if_ack_q       <= 1'b0;
            ls_ack_q       <= 1'b0;
            ls_err_q       <= 1'b0;
            busy_q         <= 1'b0;
            if_rdata_q     <= '0;
            ls_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            gnt_ls_q       <= gnt_ls_d;
            last_ls_q      <= last_ls_d;
            we_q           <= we_d;
            bad_q          <= bad_d;
            mem_addr_q     <= mem_addr_d;
            mem_write_q    <= mem_write_d;
            mem_mode_q     <= mem_mode_d;
            mem_is_read_q  <= mem_is_read_d;
            mem_is_write_q <= mem_is_write_d;
            if_ack_q       <= if_ack_d;
            ls_ack_q       <= ls_ack_d;
            ls_err_q       <= ls_err_d;
            busy_q         <= busy_d;
            if_rdata_q     <= if_rdata_d;
            ls_rdata_q     <= ls_rdata_d;
        end
    end

    assign if_ack       = if_ack_q;
    assign if_rdata     = if_rdata_q;
    assign ls_ack       = ls_ack_q;
    assign ls_rdata     = ls_rdata_q;
    assign ls_err       = ls_err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_write    = mem_write_q;
    assign mem_is_read  = mem_is_read_q;
    assign mem_is_write = mem_is_write_q;
    assign mem_mode     = mem_mode_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: directed cases plus randomized two-port traffic
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_ack, ls_err;
    logic [2:0]  ls_mode, mem_mode;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_write, mem_read;
    logic        mem_is_read, mem_is_write, busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_mode(ls_mode), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_is_read(mem_is_read),
        .mem_is_write(mem_is_write), .mem_mode(mem_mode), .mem_read(mem_read),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory seen by the DUT, and an independent reference image updated on acks
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
        int n;
        n = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + 8'(i))] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            mem[8'(a[7:0] + 8'(i))]     = d[8*i +: 8];
            ref_mem[8'(a[7:0] + 8'(i))] = d[8*i +: 8];
        end
    endtask

    always @(posedge clk) begin
        if (mem_is_read)
            mem_read <= {mem[{mem_addr[7:2], 2'b11}], mem[{mem_addr[7:2], 2'b10}],
                         mem[{mem_addr[7:2], 2'b01}], mem[{mem_addr[7:2], 2'b00}]};
        if (mem_is_write) begin
            mem[mem_addr[7:0]] = mem_write[7:0];
            if (mem_mode[1:0] != 2'b00) mem[mem_addr[7:0] + 8'd1] = mem_write[15:8];
            if (mem_mode[1:0] == 2'b10) begin
                mem[mem_addr[7:0] + 8'd2] = mem_write[23:16];
                mem[mem_addr[7:0] + 8'd3] = mem_write[31:24];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Transaction-level monitor state
    int          n_str = 0, n_wr = 0;
    int          s_cyc = -100;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_mode;
    logic        s_we;
    bit          mon_en = 0;
    bit          prev_if_ack = 0, prev_ls_ack = 0;
    bit          have_last = 0, last_port = 0, other_req_last = 0;
    logic [31:0] if_exp_addr, ls_exp_addr, ls_exp_wdata, exp_ls_rdata;
    logic [2:0]  ls_exp_mode;
    logic        ls_exp_we;

    always @(negedge clk) begin
        if (mem_is_read || mem_is_write) begin
            n_str++;
            if (mem_is_write) n_wr++;
            s_cyc = cyc; s_addr = mem_addr; s_mode = mem_mode;
            s_we = mem_is_write; s_wdata = mem_write;
        end
        if (mon_en && (if_ack || ls_ack)) begin
            bit port;
            port = ls_ack;
            check("ack_exclusive", 32'(if_ack && ls_ack), 32'd0);
            if (if_ack) check("if_ack_pulse", 32'(prev_if_ack), 32'd0);
            if (ls_ack) check("ls_ack_pulse", 32'(prev_ls_ack), 32'd0);
            if (have_last && other_req_last) check("rr_order", 32'(port), 32'(!last_port));
            have_last      = 1;
            last_port      = port;
            other_req_last = port ? if_req : ls_req;
            check("strobe_latency", 32'(cyc - s_cyc), 32'd2);
            if (!port) begin
                check("if_addr", s_addr, if_exp_addr);
                check("if_mode", 32'(s_mode), 32'd2);
                check("if_is_write", 32'(s_we), 32'd0);
                check("if_rdata", if_rdata, ref_word(if_exp_addr));
            end else begin
                check("ls_addr", s_addr, ls_exp_addr);
                check("ls_mode", 32'(s_mode), 32'(ls_exp_mode));
                check("ls_is_write", 32'(s_we), 32'(ls_exp_we));
                check("ls_err", 32'(ls_err), 32'd0);
                if (ls_exp_we) begin
                    check("ls_wdata", s_wdata, ls_exp_wdata);
                    ref_store(ls_exp_addr, ls_exp_mode, ls_exp_wdata);
                end else begin
                    exp_ls_rdata = ref_word(ls_exp_addr);
                end
                check("ls_rdata", ls_rdata, exp_ls_rdata);
            end
        end
        prev_if_ack = if_ack;
        prev_ls_ack = ls_ack;
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) at negedges for a port's ack; returns the number of cycles waited
    task automatic wait_ack(input bit ls, output int s);
        s = 0;
        do begin
            @(negedge clk);
            s++;
        end while (!(ls ? ls_ack : if_ack) && s < 20);
        check(ls ? "ls_ack_seen" : "if_ack_seen", 32'(ls ? ls_ack : if_ack), 32'd1);
    endtask

    task automatic drive_if(input int n);
        int s;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_exp_addr = 32'h80 + 32'($urandom_range(0, 31) << 2);
            if_addr = if_exp_addr;
            if_req  = 1'b1;
            wait_ack(1'b0, s);
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic drive_ls(input int n);
        logic [2:0] modes [5];
        int s, m, sz;
        modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            m  = $urandom_range(0, 4);
            sz = (modes[m][1:0] == 2'b00) ? 1 : (modes[m][1:0] == 2'b01) ? 2 : 4;
            ls_exp_mode  = modes[m];
            ls_exp_addr  = 32'($urandom_range(0, 127)) & ~32'(sz - 1);
            ls_exp_we    = modes[m][2] ? 1'b0 : 1'($urandom_range(0, 1));
            ls_exp_wdata = $urandom;
            ls_mode = ls_exp_mode; ls_addr = ls_exp_addr;
            ls_we = ls_exp_we; ls_wdata = ls_exp_wdata;
            ls_req = 1'b1;
            wait_ack(1'b1, s);
            @(posedge clk); #1;
            ls_req = 1'b0;
        end
    endtask

    initial begin
        int s, ia, la, base;
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_mode = 0; ls_addr = 0; ls_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        preload(32'h10, 32'h00112233);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_busy", 32'(busy), 0);
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_ls_ack", 32'(ls_ack), 0);
        check("rst_ls_err", 32'(ls_err), 0);
        check("rst_is_read", 32'(mem_is_read), 0);
        check("rst_is_write", 32'(mem_is_write), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_mode", 32'(mem_mode), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);

        // Single fetch: strobe one cycle after sampling, ack two cycles later
        if_req = 1; if_addr = 32'h10; rst = 0;
        step();
        check("f_is_read", 32'(mem_is_read), 1);
        check("f_is_write", 32'(mem_is_write), 0);
        check("f_addr", mem_addr, 32'h10);
        check("f_mode", 32'(mem_mode), 2);
        check("f_busy", 32'(busy), 1);
        if_addr = 32'h44;
        step();
        check("f_is_read_off", 32'(mem_is_read), 0);
        check("f_no_early_ack", 32'(if_ack), 0);
        check("f_addr_held", mem_addr, 32'h10);
        step();
        check("f_ack", 32'(if_ack), 1);
        check("f_rdata", if_rdata, 32'h00112233);
        check("f_busy_done", 32'(busy), 0);
        if_req = 0;
        step();
        check("f_ack_pulse", 32'(if_ack), 0);
        check("f_rdata_held", if_rdata, 32'h00112233);

        // Tie from reset: fetch first, load/store three cycles later
        rst = 1; step();
        if_req = 1; if_addr = 32'h84;
        ls_req = 1; ls_we = 0; ls_mode = 3'b010; ls_addr = 32'h24;
        rst = 0;
        ia = 0; la = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (if_ack) begin ia = k; if_req = 0; end
            if (ls_ack) begin la = k; ls_req = 0; end
        end
        check("tie_if_cycle", 32'(ia), 3);
        check("tie_ls_cycle", 32'(la), 6);
        check("tie_if_rdata", if_rdata, ref_word(32'h84));
        check("tie_ls_rdata", ls_rdata, ref_word(32'h24));
        exp_ls_rdata = ref_word(32'h24);

        // Store then load of the same word
        base = n_wr;
        ls_we = 1; ls_mode = 3'b010; ls_addr = 32'h20; ls_wdata = 32'hDEADBEEF; ls_req = 1;
        wait_ack(1'b1, s);
        check("st_latency", 32'(s), 3);
        check("st_rdata_kept", ls_rdata, exp_ls_rdata);
        ls_req = 0;
        ref_store(32'h20, 3'b010, 32'hDEADBEEF);
        step();
        ls_we = 0; ls_req = 1;
        wait_ack(1'b1, s);
        check("ld_rdata", ls_rdata, 32'hDEADBEEF);
        check("st_one_write", 32'(n_wr - base), 1);
        ls_req = 0;
        exp_ls_rdata = 32'hDEADBEEF;
        step();

        // Reset during RESP: outputs clear without a clock edge; held request re-runs
        if_req = 1; if_addr = 32'h88;
        step(); step();
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_if_ack", 32'(if_ack), 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_mem_mode", 32'(mem_mode), 0);
        check("mid_rst_ls_rdata", ls_rdata, 0);
        check("mid_rst_if_rdata", if_rdata, 0);
        @(negedge clk);
        check("mid_rst_no_ack", 32'(if_ack), 0);
        rst = 0;
        exp_ls_rdata = 0;
        wait_ack(1'b0, s);
        check("mid_retry_latency", 32'(s), 3);
        check("mid_retry_rdata", if_rdata, ref_word(32'h88));
        if_req = 0;
        step();

        // Misaligned word load
        base = n_str;
        ls_we = 0; ls_mode = 3'b010; ls_addr = 32'h22; ls_req = 1;
        wait_ack(1'b1, s);
`ifdef MEM_ARB_ALIGN_CHK_EN
        check("mis_no_strobe", 32'(n_str - base), 0);
        check("mis_err", 32'(ls_err), 1);
        check("mis_rdata_kept", ls_rdata, exp_ls_rdata);
`else
        check("mis_strobe", 32'(n_str - base), 1);
        check("mis_err", 32'(ls_err), 0);
        check("mis_rdata", ls_rdata, ref_word(32'h20));
        exp_ls_rdata = ref_word(32'h20);
`endif
        ls_req = 0;
        step(); step();

        // Randomized concurrent traffic checked by the transaction monitor
        mon_en = 1;
        fork
            drive_if(40);
            drive_ls(40);
        join
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
